ha_array_row_accum_ctrl: RTL and testbench



---
 rtl/ha_array_row_accum_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ha_array_row_accum_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ha_array_row_accum_ctrl.sv
// Sequencing controller for the unsigned 8x8 approximate half-adder-array multiplier.
// Latency: product valid 5 cycles after the accept cycle (4 serial row-accumulate cycles), 1 product / 5 cycles.
// Backpressure: holds the product in DONE while out_ready=0; in_ready is low in ACC and in DONE without out_ready.
//
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   in_valid/in_ready, x, y      operand pair handshake
//   mul_x, mul_y                 registered operands feeding the combinational ha_array stage
//   ha_array_{0..3}_b / _t       the stage's four reduced rows (7-bit carry, 9-bit sum)
//   out_valid/out_ready, p, ovf  product handshake, product and overflow flag
module ha_array_row_accum_ctrl #(
  parameter int OUT_W    = 16,
  parameter int ACC_W    = 17,   // keep >= OUT_W+1 so the overflow is observable
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       x,
  input  logic [7:0]       y,
  output logic [7:0]       mul_x,
  output logic [7:0]       mul_y,
  input  logic [6:0]       ha_array_0_b,
  input  logic [8:0]       ha_array_0_t,
  input  logic [6:0]       ha_array_1_b,
  input  logic [8:0]       ha_array_1_t,
  input  logic [6:0]       ha_array_2_b,
  input  logic [8:0]       ha_array_2_t,
  input  logic [6:0]       ha_array_3_b,
  input  logic [8:0]       ha_array_3_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] p,
  output logic             ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Largest representable product, zero-extended to the accumulator width.
  localparam logic [ACC_W-1:0] P_MAX = ACC_W'({OUT_W{1'b1}});

  state_t             state_q, state_d;
  logic [7:0]         mul_x_q, mul_x_d;
  logic [7:0]         mul_y_q, mul_y_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [OUT_W-1:0]   p_q, p_d;
  logic               ovf_q, ovf_d;

  logic [8:0]         row_t;
  logic [6:0]         row_b;
  logic [9:0]         row_raw;
  logic [ACC_W-1:0]   row_val;
  logic [ACC_W-1:0]   acc_sum;
  logic               sum_ovf;
  logic [OUT_W-1:0]   sum_p;
  logic               accept;

  // Row currently being folded in; the ha_array inputs are stable during ACC
  // because mul_x/mul_y only change on an accept.
  always_comb begin
    row_t = ha_array_0_t;
    row_b = ha_array_0_b;
    case (cnt_q)
      2'd1: begin
        row_t = ha_array_1_t;
        row_b = ha_array_1_b;
      end
      2'd2: begin
        row_t = ha_array_2_t;
        row_b = ha_array_2_b;
      end
      2'd3: begin
        row_t = ha_array_3_t;
        row_b = ha_array_3_b;
      end
      default: begin
        row_t = ha_array_0_t;
        row_b = ha_array_0_b;
      end
    endcase
  end

  // Carry bits sit two places above the sum bits; row k is then weighted by 4^k.
  assign row_raw = {1'b0, row_t} + {1'b0, row_b, 2'b00};
  assign row_val = ACC_W'(row_raw) << {cnt_q, 1'b0};
  assign acc_sum = acc_q + row_val;

  // Output value is resolved on the final ACC edge so DONE presents pure flops.
  assign sum_ovf = (acc_sum > P_MAX);
  assign sum_p   = (SATURATE && sum_ovf) ? P_MAX[OUT_W-1:0] : acc_sum[OUT_W-1:0];

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    mul_x_d = mul_x_q;
    mul_y_d = mul_y_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mul_x_d = x;
          mul_y_d = y;
          acc_d   = '0;
          cnt_d   = 2'd0;
          state_d = ST_ACC;
        end
      end

      ST_ACC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          p_d     = sum_p;
          ovf_d   = sum_ovf;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            // Back-to-back: the consume edge doubles as the next accept edge.
            mul_x_d = x;
            mul_y_d = y;
            acc_d   = '0;
            cnt_d   = 2'd0;
            state_d = ST_ACC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mul_x_q <= '0;
      mul_y_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mul_x_q <= mul_x_d;
      mul_y_q <= mul_y_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign out_valid = (state_q == ST_DONE);
  assign p         = p_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ha_array_row_accum_ctrl.sv
// Bench for ha_array_row_accum_ctrl: two instances (saturating and truncating) share
// all inputs; expected products come from a row-weighting model pushed at accept time.
module tb_ha_array_row_accum_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        out_ready;
  logic [8:0]  t_stub [4];
  logic [6:0]  b_stub [4];

  logic        in_ready_s, in_ready_t;
  logic [7:0]  mul_x_s, mul_y_s, mul_x_t, mul_y_t;
  logic        out_valid_s, out_valid_t;
  logic [15:0] p_s, p_t;
  logic        ovf_s, ovf_t;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] p_sat;
    logic [15:0] p_trunc;
    logic        ovf;
    logic [7:0]  mx;
    logic [7:0]  my;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] last_p_sat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ha_array_row_accum_ctrl #(.OUT_W(16), .ACC_W(17), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_s), .x(x), .y(y),
    .mul_x(mul_x_s), .mul_y(mul_y_s),
    .ha_array_0_b(b_stub[0]), .ha_array_0_t(t_stub[0]),
    .ha_array_1_b(b_stub[1]), .ha_array_1_t(t_stub[1]),
    .ha_array_2_b(b_stub[2]), .ha_array_2_t(t_stub[2]),
    .ha_array_3_b(b_stub[3]), .ha_array_3_t(t_stub[3]),
    .out_valid(out_valid_s), .out_ready(out_ready), .p(p_s), .ovf(ovf_s)
  );

  ha_array_row_accum_ctrl #(.OUT_W(16), .ACC_W(17), .SATURATE(1'b0)) u_trunc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_t), .x(x), .y(y),
    .mul_x(mul_x_t), .mul_y(mul_y_t),
    .ha_array_0_b(b_stub[0]), .ha_array_0_t(t_stub[0]),
    .ha_array_1_b(b_stub[1]), .ha_array_1_t(t_stub[1]),
    .ha_array_2_b(b_stub[2]), .ha_array_2_t(t_stub[2]),
    .ha_array_3_b(b_stub[3]), .ha_array_3_t(t_stub[3]),
    .out_valid(out_valid_t), .out_ready(out_ready), .p(p_t), .ovf(ovf_t)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stubs();
    for (int k = 0; k < 4; k++) begin
      t_stub[k] = '0;
      b_stub[k] = '0;
    end
  endtask

  // Model: t[j] weighs 2^(j+2k), b[j] weighs 2^(j+2+2k).
  task automatic push_exp(input logic [7:0] ex, input logic [7:0] ey);
    int   sum;
    exp_t e;
    sum = 0;
    for (int k = 0; k < 4; k++)
      sum += (int'(t_stub[k]) + 4 * int'(b_stub[k])) * (1 << (2 * k));
    e.p_sat   = (sum > 65535) ? 16'hFFFF : sum[15:0];
    e.p_trunc = sum[15:0];
    e.ovf     = (sum > 65535);
    e.mx      = ex;
    e.my      = ey;
    sb_q.push_back(e);
  endtask

  // Called positioned at a negedge; presents the pair for one cycle.
  task automatic accept(input logic [7:0] ex, input logic [7:0] ey, input bit do_push);
    x = ex;
    y = ey;
    in_valid = 1'b1;
    #1;
    check("accept_in_ready", {31'd0, in_ready_s}, 32'd1);
    if (do_push) push_exp(ex, ey);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts negedges after the accept edge until out_valid, then compares to the scoreboard.
  task automatic wait_check(input int lat);
    int   found_at;
    exp_t e;
    found_at = 0;
    for (int n = 1; n <= 20 && found_at == 0; n++) begin
      @(negedge clk);
      if (out_valid_s === 1'b1) found_at = n;
    end
    check("latency", found_at, lat);
    if (found_at != 0) begin
      check("sb_nonempty", {31'd0, sb_q.size() > 0}, 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        last_p_sat = e.p_sat;
        check("p_sat",       {16'd0, p_s},   {16'd0, e.p_sat});
        check("p_trunc",     {16'd0, p_t},   {16'd0, e.p_trunc});
        check("ovf_sat",     {31'd0, ovf_s}, {31'd0, e.ovf});
        check("ovf_trunc",   {31'd0, ovf_t}, {31'd0, e.ovf});
        check("mul_x",       {24'd0, mul_x_s}, {24'd0, e.mx});
        check("mul_y",       {24'd0, mul_y_s}, {24'd0, e.my});
        check("valid_trunc", {31'd0, out_valid_t}, 32'd1);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    y         = '0;
    last_p_sat = '0;
    clear_stubs();

    // Reset / idle
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready_s},  32'd1);
    check("rst_out_valid", {31'd0, out_valid_s}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready",  {31'd0, in_ready_s},  32'd1);
    check("idle_out_valid", {31'd0, out_valid_s}, 32'd0);
    check("idle_p",         {16'd0, p_s},         32'd0);
    check("idle_ovf",       {31'd0, ovf_s},       32'd0);
    check("idle_mul_x",     {24'd0, mul_x_s},     32'd0);
    check("idle_mul_y",     {24'd0, mul_y_s},     32'd0);

    // Single row: p = 1
    t_stub[0] = 9'h001;
    accept(8'h12, 8'h34, 1'b1);
    wait_check(5);
    @(negedge clk);
    check("post_done_valid", {31'd0, out_valid_s}, 32'd0);
    check("post_done_hold_p", {16'd0, p_s}, 32'd1);

    // Weighting: b3 bit0 -> 256
    clear_stubs();
    b_stub[3] = 7'h01;
    accept(8'h01, 8'h01, 1'b1);
    wait_check(5);
    @(negedge clk);

    // Weighting: t2 bit8 -> 4096
    clear_stubs();
    t_stub[2] = 9'h100;
    accept(8'hFF, 8'h80, 1'b1);
    wait_check(5);
    @(negedge clk);

    // Saturation with zero operands (no short-circuit): sum 86615
    for (int k = 0; k < 4; k++) begin
      t_stub[k] = 9'h1FF;
      b_stub[k] = 7'h7F;
    end
    accept(8'h00, 8'h00, 1'b1);
    wait_check(5);
    @(negedge clk);

    // Back-pressure in DONE
    clear_stubs();
    t_stub[1] = 9'h0AB;
    b_stub[0] = 7'h11;
    out_ready = 1'b0;
    accept(8'hA5, 8'h5A, 1'b1);
    wait_check(5);
    repeat (4) begin
      @(negedge clk);
      check("bp_valid",    {31'd0, out_valid_s}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready_s},  32'd0);
      check("bp_p_stable", {16'd0, p_s},         {16'd0, last_p_sat});
    end

    // Back-to-back: consume and accept on the same edge
    clear_stubs();
    t_stub[3] = 9'h033;
    b_stub[2] = 7'h40;
    out_ready = 1'b1;
    accept(8'h3C, 8'hC3, 1'b1);
    wait_check(5);
    @(negedge clk);

    // Reset two cycles into ACC
    clear_stubs();
    t_stub[0] = 9'h0FF;
    accept(8'h77, 8'h88, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",    {31'd0, out_valid_s}, 32'd0);
    check("mid_rst_p",        {16'd0, p_s},         32'd0);
    check("mid_rst_ovf",      {31'd0, ovf_s},       32'd0);
    check("mid_rst_mul_x",    {24'd0, mul_x_s},     32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready_s},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_no_valid", {31'd0, out_valid_s}, 32'd0);
    end
    clear_stubs();
    t_stub[1] = 9'h005;
    b_stub[1] = 7'h02;
    accept(8'h01, 8'h02, 1'b1);
    wait_check(5);
    @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
